// File: rtl/byte_pack_pkg.sv
// byte_pack_pkg: shared states, mode/select codes and default widths for the byte pair packer
package byte_pack_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic MODE_CONCAT = 1'b0;
  localparam logic MODE_REPL = 1'b1;
  localparam logic [1:0] SEL_CAT = 2'd0;
  localparam logic [1:0] SEL_REP = 2'd1;
  localparam logic [1:0] SEL_PART = 2'd2;
  localparam int DEF_BYTE_W = 8;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/byte_combine.sv
// byte_combine: forms a double-width word from held/incoming bytes (concat, replicate or zero-padded partial)
module byte_combine
  import byte_pack_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic [BYTE_W-1:0]   held,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic [1:0]          sel,
  output logic [2*BYTE_W-1:0] word
);
  always_comb
    word = sel == SEL_PART ? {held, {BYTE_W{1'b0}}} :
           sel == SEL_REP  ? {in_data, in_data} :
                             {held, in_data};
endmodule

// File: rtl/byte_pair_packer.sv
// byte_pair_packer: packs or replicates a byte stream into registered 16-bit words with flush and word count
module byte_pair_packer
  import byte_pack_pkg::*;
#(
  parameter int BYTE_W = DEF_BYTE_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*BYTE_W-1:0] out_data,
  output logic                out_partial,
  output logic [CNT_W-1:0]    word_count
);
  state_t state, nxt;
  logic [BYTE_W-1:0] held;
  logic [2*BYTE_W-1:0] word;
  logic [1:0] sel;
  logic slot_free, in_acc, out_acc, load, latch;
  assign slot_free = !out_valid | out_ready;
  // gated by rst_n so the input side looks closed while reset is held
  assign in_ready = rst_n & slot_free;
  assign in_acc = in_valid & in_ready;
  assign out_acc = out_valid & out_ready;
  always_comb begin
    nxt = state;
    load = 1'b0;
    latch = 1'b0;
    sel = SEL_CAT;
    if (state == IDLE) begin
      if (in_acc && mode == MODE_REPL) begin
        load = 1'b1;
        sel = SEL_REP;
      end else if (in_acc) begin
        latch = 1'b1;
        nxt = HOLD;
      end
    end else if (in_acc) begin
      load = 1'b1;
      nxt = IDLE;
    end else if (flush && slot_free) begin
      load = 1'b1;
      sel = SEL_PART;
      nxt = IDLE;
    end
  end
  byte_combine #(.BYTE_W(BYTE_W)) u_comb (
    .held(held),
    .in_data(in_data),
    .sel(sel),
    .word(word)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      held <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_partial <= 1'b0;
      word_count <= '0;
    end else begin
      state <= nxt;
      if (latch) held <= in_data;
      if (load) begin
        out_data <= word;
        out_partial <= sel == SEL_PART;
      end
      out_valid <= load | (out_valid & !out_ready);
      word_count <= word_count + CNT_W'(out_acc);
    end
  end
endmodule

// File: tb/tb_byte_pair_packer.sv
// tb_byte_pair_packer: directed and random stimulus checked against a behavioural packer model
module tb_byte_pair_packer;
  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, out_partial;
  logic [15:0] out_data, word_count;
  int vectors = 0, miscompares = 0;
  bit m_hv, m_ov, m_op;
  logic [7:0] m_held;
  logic [15:0] m_od, m_cnt;
  always #5 clk = ~clk;
  byte_pair_packer dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_partial(out_partial), .word_count(word_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_hv = 0; m_ov = 0; m_op = 0; m_held = '0; m_od = '0; m_cnt = '0;
  endtask
  task automatic check_outs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data", {16'd0, out_data}, {16'd0, m_od});
    chk("out_partial", {31'd0, out_partial}, {31'd0, m_op});
    chk("word_count", {16'd0, word_count}, {16'd0, m_cnt});
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic m, input logic f, input logic r);
    bit free, acc, gen, part;
    logic [15:0] w;
    @(negedge clk);
    in_valid = v; in_data = d; mode = m; flush = f; out_ready = r;
    #1;
    free = !m_ov || r;
    acc = v && free;
    chk("in_ready", {31'd0, in_ready}, {31'd0, free});
    gen = 0; part = 0; w = '0;
    if (acc && m_hv) begin
      gen = 1; w = {m_held, d}; m_hv = 0;
    end else if (acc && m) begin
      gen = 1; w = {d, d};
    end else if (acc) begin
      m_hv = 1; m_held = d;
    end else if (m_hv && f && free) begin
      gen = 1; part = 1; w = {m_held, 8'h00}; m_hv = 0;
    end
    if (m_ov && r) m_cnt = m_cnt + 16'd1;
    if (gen) begin
      m_ov = 1; m_od = w; m_op = part;
    end else if (r) m_ov = 0;
    @(posedge clk);
    #1;
    check_outs();
  endtask
  task automatic async_reset();
    @(negedge clk);
    in_valid = 0; flush = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("in_ready_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_reset();
    #1;
    chk("in_ready_rst", {31'd0, in_ready}, 32'd0);
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'hA5, 1, 0, 1);
    chk("rep_a5", {16'd0, out_data}, 32'hA5A5);
    cyc(1, 8'h3C, 1, 0, 1);
    chk("rep_3c", {16'd0, out_data}, 32'h3C3C);
    cyc(0, 8'h00, 1, 0, 1);
    chk("rep_cnt", {16'd0, word_count}, 32'd2);
    cyc(1, 8'h12, 0, 0, 1);
    chk("cat_first_none", {31'd0, out_valid}, 32'd0);
    cyc(1, 8'h34, 0, 0, 1);
    chk("cat_1234", {16'd0, out_data}, 32'h1234);
    cyc(1, 8'hEF, 0, 0, 1);
    cyc(0, 8'h00, 0, 1, 1);
    chk("flush_ef00", {15'd0, out_partial, out_data}, 32'h1EF00);
    cyc(0, 8'h00, 0, 1, 1);
    chk("flush_idle_none", {31'd0, out_valid}, 32'd0);
    cyc(1, 8'hAB, 1, 0, 0);
    cyc(1, 8'h11, 1, 0, 0);
    chk("bp_stable", {16'd0, out_data}, 32'hABAB);
    cyc(1, 8'h11, 1, 0, 1);
    chk("bp_nobubble", {15'd0, out_valid, out_data}, 32'h11111);
    cyc(1, 8'h56, 0, 0, 1);
    cyc(1, 8'h78, 0, 1, 1);
    chk("flush_and_acc", {15'd0, out_partial, out_data}, 32'h05678);
    cyc(0, 8'h00, 0, 1, 1);
    chk("flush_acc_no_extra", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(3) != 0, 8'($urandom), 1'($urandom), $urandom_range(4) == 0, $urandom_range(9) < 7);
    cyc(1, 8'hC3, 1, 0, 0);
    async_reset();
    cyc(1, 8'h9A, 0, 0, 1);
    async_reset();
    cyc(0, 8'h00, 0, 1, 1);
    chk("no_partial_after_rst", {31'd0, out_valid}, 32'd0);
    cyc(1, 8'h01, 1, 0, 1);
    while (m_cnt != 16'hFFFF) cyc(1, 8'($urandom), 1, 0, 1);
    chk("cnt_ffff", {16'd0, word_count}, 32'hFFFF);
    cyc(0, 8'h00, 1, 0, 1);
    chk("cnt_wrap", {16'd0, word_count}, 32'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/byte_pair_packer.md
Name: byte_pair_packer

Overview:
- Sequences an 8-bit-to-16-bit combining datapath for a byte stream.
- Concatenate mode: packs consecutive bytes into 16-bit words, first byte in the upper half.
- Replicate mode: expands each byte into a 16-bit word holding two copies of that byte.
- Valid/ready handshake on both sides, a registered output, a flush for a dangling odd byte, and a count of emitted words.

Parameters:
- BYTE_W, 8, input byte width. Output word width is 2*BYTE_W.
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = concatenate, 1 = replicate. Sampled only when a new byte is accepted in IDLE.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  BYTE_W  input byte.
- flush  input  1  level: emit any held odd byte as a partial word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  2*BYTE_W  packed word.
- out_partial  output  1  qualifies out_data: word came from a flush; lower byte is zero.
- word_count  output  CNT_W  number of words accepted downstream (out_valid and out_ready).

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; held byte = 0.
  - out_valid = 0, out_data = 0, out_partial = 0, word_count = 0.
  - in_ready is combinational from state and out_valid; it is 0 while rst_n is low.
- Handshakes:
  - in accept = in_valid & in_ready.
  - out accept = out_valid & out_ready.
  - Output register slot is free = !out_valid | out_ready. This is a same-cycle pass-through of out_ready; no skid buffer.
  - in_ready = slot free, in both IDLE and HOLD.
- States:
  - IDLE: no byte held.
  - HOLD: first byte of a concat pair held.
- IDLE transitions:
  - Accept with mode=1: load out_data = {in_data, in_data}, out_partial = 0, out_valid = 1 next cycle. Stay in IDLE.
  - Accept with mode=0: latch the byte into the held register, go to HOLD. No output.
  - flush in IDLE: no effect.
- HOLD transitions:
  - Accept: load out_data = {held, in_data}, out_partial = 0, out_valid = 1. Return to IDLE. mode is ignored.
  - flush with no accept and slot free: load out_data = {held, 0}, out_partial = 1, out_valid = 1. Return to IDLE.
  - flush with slot not free: wait in HOLD until the slot is free.
  - flush and accept in the same cycle: the pair completes normally and flush has no effect.
- Latency and throughput:
  - Completing byte accepted at cycle N gives out_valid at cycle N+1.
  - With out_ready held high: replicate mode sustains 1 word/cycle; concat mode sustains 1 word per 2 cycles.
- Output hold: out_valid, out_data and out_partial stay stable while out_valid & !out_ready.
- Clearing out_valid: cleared on out accept unless a new word loads in the same cycle. A back-to-back load replaces the word with no bubble.
- word_count: increments by 1 on each out accept and wraps modulo 2^CNT_W.
- mode changes while in HOLD take effect only on the next accept in IDLE.
- Reset mid-operation: any held byte and pending output are discarded with no partial emitted.

Decomposition:
- Shared package byte_pack_pkg:
  - state enum {IDLE, HOLD}.
  - Localparams MODE_CONCAT = 0 and MODE_REPL = 1.
  - Default widths BYTE_W and CNT_W.
- One sub-module, byte_combine: purely combinational. It takes held, in_data, sel[1:0] (concat / replicate / partial) and produces the 16-bit word.
- Top level holds the FSM, output register and counter.

Test Plan:
- Replicate stream, out_ready = 1: bytes 0xA5, 0x3C on consecutive cycles -> out_data 0xA5A5 then 0x3C3C on consecutive cycles, out_partial = 0, word_count = 2.
- Concat pair: mode = 0, bytes 0x12 then 0x34 -> single word 0x1234 one cycle after 0x34 is accepted; no output after 0x12.
- Flush of odd byte:
  - mode = 0, byte 0xEF, then flush = 1 -> 0xEF00 with out_partial = 1.
  - flush in IDLE produces nothing.
- Backpressure:
  - out_ready = 0 with word 0xABAB pending -> out_data stable and in_ready = 0.
  - Raise out_ready with in_valid = 1, data 0x11 -> 0xABAB consumed and 0x1111 loaded the next cycle with no bubble.
- Simultaneous flush and accept in HOLD (held 0x56, in 0x78) -> 0x5678 with out_partial = 0; no extra word.
- Counter wrap and reset:
  - Preset to 0xFFFF via 65535 accepts (or forced) -> next accept gives word_count = 0x0000.
  - Assert rst_n = 0 while in HOLD with out_valid = 1 -> all outputs 0 asynchronously; no partial after release.
